// File: rtl/alu_exec_unit.sv
// Execute-stage ALU consuming the decoder's 4-bit control code over valid/ready.
// Single-entry unit: shifts iterate SHIFT_STEP bits per cycle, everything else completes in one cycle.
module alu_exec_unit #(
    parameter int          XLEN       = 32,
    parameter int          SHIFT_STEP = 4,
    parameter logic [3:0]  JMP_CODE   = 4'b1111,
    parameter int          JMP_OFFSET = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} shift_kind_t;

    localparam logic [5:0] STEP6 = 6'(SHIFT_STEP);

    state_t          state, state_n;
    shift_kind_t     kind_p1, kind_n;
    logic [XLEN-1:0] shv_p1, shv_n;
    logic [5:0]      rem_p1, rem_n;
    logic [5:0]      step_amt;
    logic [XLEN-1:0] result_p1, res_n;
    logic            zero_p1;
    logic            illegal_p1, ill_n;
    logic            req_is_shift;
    logic [4:0]      req_sh;
    shift_kind_t     req_kind;

    // Branch codes return 1 when the branch is NOT taken, so zero doubles as branch-taken.
    function automatic logic [XLEN:0] alu_compute(input logic [3:0]      ctrl,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [XLEN-1:0]        r;
        logic                   ill;
        sa  = a;
        sb  = b;
        r   = '0;
        ill = 1'b0;
        if (ctrl == JMP_CODE) begin
            r = a + XLEN'(JMP_OFFSET);
        end else begin
            case (ctrl)
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001, 4'b0101, 4'b1101: r = a;
                4'b0010: r = XLEN'(sa < sb);
                4'b0011: r = XLEN'(a < b);
                4'b0100: r = a ^ b;
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                4'b1100: r = XLEN'(a == b);
                4'b1010: r = XLEN'(sa < sb);
                4'b1011: r = XLEN'(a < b);
                default: begin
                    r   = '0;
                    ill = 1'b1;
                end
            endcase
        end
        return {ill, r};
    endfunction

    function automatic logic [XLEN-1:0] shift_step(input shift_kind_t     k,
                                                   input logic [XLEN-1:0] v,
                                                   input logic [5:0]      n);
        logic signed [XLEN-1:0] sv;
        logic [XLEN-1:0]        r;
        sv = v;
        case (k)
            K_SLL:   r = v << n;
            K_SRL:   r = v >> n;
            default: r = sv >>> n;
        endcase
        return r;
    endfunction

    always_comb begin
        req_sh       = op_b[4:0];
        req_is_shift = 1'b0;
        req_kind     = K_SLL;
        case (alu_ctrl)
            4'b0001: req_is_shift = (JMP_CODE != 4'b0001);
            4'b0101: begin
                req_is_shift = (JMP_CODE != 4'b0101);
                req_kind     = K_SRL;
            end
            4'b1101: begin
                req_is_shift = (JMP_CODE != 4'b1101);
                req_kind     = K_SRA;
            end
            default: req_is_shift = 1'b0;
        endcase
    end

    assign step_amt = (rem_p1 >= STEP6) ? STEP6 : rem_p1;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        res_n    = result_p1;
        ill_n    = illegal_p1;
        shv_n    = shv_p1;
        rem_n    = rem_p1;
        kind_n   = kind_p1;
        case (state)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                if (rem_p1 == 6'd0) begin
                    res_n   = shv_p1;
                    ill_n   = 1'b0;
                    state_n = DONE;
                end else begin
                    shv_n = shift_step(kind_p1, shv_p1, step_amt);
                    rem_n = rem_p1 - step_amt;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (in_ready && in_valid) begin
            if (req_is_shift && (req_sh != 5'd0)) begin
                shv_n   = op_a;
                rem_n   = {1'b0, req_sh};
                kind_n  = req_kind;
                state_n = SHIFT;
            end else begin
                {ill_n, res_n} = alu_compute(alu_ctrl, op_a, op_b);
                state_n        = DONE;
            end
        end
    end

    // Request capture / shift iteration / result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            kind_p1    <= K_SLL;
            shv_p1     <= '0;
            rem_p1     <= '0;
            result_p1  <= '0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            state      <= state_n;
            kind_p1    <= kind_n;
            shv_p1     <= shv_n;
            rem_p1     <= rem_n;
            result_p1  <= res_n;
            zero_p1    <= (res_n == '0);
            illegal_p1 <= ill_n;
        end
    end

    assign out_valid = (state == DONE);
    assign result    = result_p1;
    assign zero      = zero_p1;
    assign illegal   = illegal_p1 & out_valid;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed steps plus a random mix, checked with immediate assertions.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int passes = 0;
    logic [33:0] sb_q[$];

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {illegal, zero, result}
    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        int          sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        case (c)
            4'h0: r = a + b;
            4'h8: r = a + ~b + 32'd1;
            4'h1: r = a << sh;
            4'h5: r = a >> sh;
            4'hD: r = 32'($signed(a) >>> sh);
            4'h2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: r = (a < b) ? 32'd1 : 32'd0;
            4'h4: r = a ^ b;
            4'h6: r = a | b;
            4'h7: r = a & b;
            4'hC: r = (a != b) ? 32'd0 : 32'd1;
            4'hA: r = ($signed(a) >= $signed(b)) ? 32'd0 : 32'd1;
            4'hB: r = (a >= b) ? 32'd0 : 32'd1;
            4'hF: r = a + 32'd4;
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n        = 0;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb_q.push_back(model(c, a, b));
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        #1;
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", result, e[31:0]);
                check("zero", {31'd0, zero}, {31'd0, e[32]});
                check("illegal", {31'd0, illegal}, {31'd0, e[33]});
            end
        end
    end

    initial begin
        logic [31:0] held;
        logic [3:0]  fast_codes [13];
        fast_codes = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hC, 4'hA, 4'hB, 4'hF, 4'h9, 4'hE};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 4'h0; op_a = 32'd0; op_b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send(4'h0, 32'hFFFF_FFFF, 32'd1);
        check("add_latency", {31'd0, out_valid}, 32'd1);
        check("add_zero", {31'd0, zero}, 32'd1);
        send(4'h8, 32'd0, 32'd1);
        check("sub_result", result, 32'hFFFF_FFFF);
        @(negedge clk);

        send(4'hD, 32'h8000_0000, 32'd31);
        for (int i = 0; i < 9; i++) begin
            check("sra_wait_valid", {31'd0, out_valid}, 32'd0);
            check("sra_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("sra_latency", {31'd0, out_valid}, 32'd1);
        check("sra_result", result, 32'hFFFF_FFFF);
        @(negedge clk);

        send(4'hC, 32'd5, 32'd5);
        send(4'h4, 32'd5, 32'd5);
        send(4'hA, 32'hFFFF_FFFF, 32'd0);
        send(4'hB, 32'hFFFF_FFFF, 32'd0);
        send(4'hE, 32'h1234_5678, 32'h9);
        check("illegal_flag", {31'd0, illegal}, 32'd1);
        send(4'h9, 32'd7, 32'd7);
        send(4'hF, 32'h0000_1000, 32'd0);
        send(4'h1, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        send(4'h5, 32'hF000_0000, 32'd7);
        for (int i = 0; i < 4; i++) @(negedge clk);

        out_ready = 1'b0;
        send(4'h6, 32'h00F0_0000, 32'h0000_000F);
        held = result;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, held);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(4'h7, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", result, 32'h0F00_0F00);

        for (int i = 0; i < 10; i++) begin
            send(fast_codes[$urandom_range(0, 12)], $urandom, $urandom);
            check("burst_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);

        send(4'h1, 32'h0000_0001, 32'd20);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_shift_valid", {31'd0, out_valid}, 32'd0);
        check("rst_shift_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_shift_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_glitch", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [31:0] b;
            b = $urandom;
            if (i % 3 == 0) b[4:0] = 5'($urandom_range(0, 9));
            send(4'($urandom), $urandom, b);
            if (i % 4 == 0) @(negedge clk);
        end

        for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        check("drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
